// File: rtl/sram64_be_port_adapter_if.sv
// Bundle of request, response and downstream SRAM signals for sram64_be_port_adapter.
// master = requester plus SRAM side (environment); slave = the adapter itself.
interface sram64_be_port_adapter_if;
  // A handshake completes in any cycle where valid and ready are both high.
  // Ready never waits for valid, and payload is only meaningful in that cycle.
  logic        wr_valid;
  logic        wr_ready;
  logic [13:0] wr_addr;
  logic [63:0] wr_data;
  logic [63:0] wr_mask;
  logic        rd_valid;
  logic        rd_ready;
  logic [13:0] rd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        CE0;
  logic [13:0] A0;
  logic [63:0] D0;
  logic        WE0;
  logic [63:0] WEM0;
  logic        CE1;
  logic [13:0] A1;
  logic [63:0] Q1;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, Q1,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, CE0, A0, D0, WE0, WEM0, CE1, A1
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_mask, rd_valid, rd_addr, rsp_ready, Q1,
    output wr_ready, rd_ready, rsp_valid, rsp_data, CE0, A0, D0, WE0, WEM0, CE1, A1
  );
endinterface

// File: rtl/sram64_be_port_adapter.sv
// Adapts valid/ready write/read requests onto a dual-bank SRAM (write port 0, read port 1)
// with a 2-entry response FIFO and credit-based read flow control.
module sram64_be_port_adapter (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  sram64_be_port_adapter_if.slave        io_bus,
  output logic                           o_dbg_prio_wr,
  output logic [1:0]                     o_dbg_count,
  output logic                           o_dbg_inflight
);

  logic [1:0]  r_count;
  logic        r_inflight;
  logic        r_prio_wr;
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [63:0] r_fifo [2];

  logic        w_pop;
  logic [2:0]  w_level;
  logic        w_credit;
  logic        w_conflict;
  logic        w_wr_ready;
  logic        w_rd_ready;
  logic        w_wr_fire;
  logic        w_rd_fire;

  // Credit counts the slot an in-flight read will need and frees the one popped this cycle.
  always_comb begin
    w_pop      = (r_count != 2'd0) & io_bus.rsp_ready;
    w_level    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_credit   = (w_level < 3'd2);
    w_conflict = io_bus.wr_valid & io_bus.rd_valid & w_credit &
                 (io_bus.wr_addr[13] == io_bus.rd_addr[13]);
    w_wr_ready = ~w_conflict | r_prio_wr;
    w_rd_ready = w_credit & (~w_conflict | ~r_prio_wr);
    w_wr_fire  = io_bus.wr_valid & w_wr_ready;
    w_rd_fire  = io_bus.rd_valid & w_rd_ready;
  end

  assign io_bus.wr_ready  = w_wr_ready;
  assign io_bus.rd_ready  = w_rd_ready;
  assign io_bus.CE0       = w_wr_fire;
  assign io_bus.WE0       = w_wr_fire;
  assign io_bus.A0        = w_wr_fire ? io_bus.wr_addr : 14'd0;
  assign io_bus.D0        = w_wr_fire ? io_bus.wr_data : 64'd0;
  assign io_bus.WEM0      = w_wr_fire ? io_bus.wr_mask : 64'd0;
  assign io_bus.CE1       = w_rd_fire;
  assign io_bus.A1        = w_rd_fire ? io_bus.rd_addr : 14'd0;
  assign io_bus.rsp_valid = (r_count != 2'd0);
  assign io_bus.rsp_data  = r_fifo[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_prio_wr  <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
    end else begin
      r_inflight <= w_rd_fire;
      if (w_conflict) r_prio_wr <= ~r_prio_wr;
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  // Data storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (r_inflight) r_fifo[r_wr_ptr] <= io_bus.Q1;
  end

  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ({1'b0, r_count} + {2'b00, r_inflight}) <= 3'd2);

  assign o_dbg_prio_wr  = r_prio_wr;
  assign o_dbg_count    = r_count;
  assign o_dbg_inflight = r_inflight;

endmodule

// File: tb/tb_sram64_be_port_adapter.sv
// Randomized plus directed bench for sram64_be_port_adapter with an SRAM model,
// a reference memory and an expected-response queue.
module tb_sram64_be_port_adapter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram64_be_port_adapter_if bus ();
  logic       dbg_prio_wr;
  logic [1:0] dbg_count;
  logic       dbg_inflight;

  sram64_be_port_adapter dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .io_bus         (bus),
    .o_dbg_prio_wr  (dbg_prio_wr),
    .o_dbg_count    (dbg_count),
    .o_dbg_inflight (dbg_inflight)
  );

  int checks = 0;
  int errors = 0;
  int n_wr_hs = 0;
  int n_rd_hs = 0;
  int n_rsp = 0;
  logic [63:0] exp_q [$];
  logic [63:0] ref_mem [0:16383];
  logic [63:0] sram [0:16383];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Downstream SRAM: masked write on port 0, one-cycle read on port 1.
  always @(posedge clk) begin
    if (bus.CE0 && bus.WE0)
      sram[bus.A0] = (sram[bus.A0] & ~bus.WEM0) | (bus.D0 & bus.WEM0);
    if (bus.CE1) bus.Q1 <= sram[bus.A1];
  end

  // Issue observer: updates the reference memory and pushes expected read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.wr_valid && bus.wr_ready) begin
        ref_mem[bus.wr_addr] = (ref_mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
        n_wr_hs++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        exp_q.push_back(ref_mem[bus.rd_addr]);
        n_rd_hs++;
      end
      check("ce0_is_wr_hs", {63'd0, bus.CE0}, {63'd0, bus.wr_valid & bus.wr_ready});
      check("ce1_is_rd_hs", {63'd0, bus.CE1}, {63'd0, bus.rd_valid & bus.rd_ready});
      if (bus.CE0 && bus.CE1)
        check("bank_split", {63'd0, bus.A0[13] ^ bus.A1[13]}, 64'd1);
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got %h expected no response", bus.rsp_data);
      end else begin
        check("rsp_data", bus.rsp_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.rd_addr  = '0;
  endtask

  task automatic drain();
    idle();
    bus.rsp_ready = 1'b1;
    repeat (5) step();
  endtask

  task automatic do_write(input logic [13:0] a, input logic [63:0] d, input logic [63:0] m);
    idle();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_mask  = m;
    #1;
    check("wr_ready_solo", {63'd0, bus.wr_ready}, 64'd1);
    step();
    idle();
  endtask

  // Read with the latency check: response invisible one cycle after, visible two after.
  task automatic read_latency(input logic [13:0] a, input logic [63:0] exp_data);
    idle();
    bus.rsp_ready = 1'b1;
    bus.rd_valid  = 1'b1;
    bus.rd_addr   = a;
    #1;
    check("rd_ready_solo", {63'd0, bus.rd_ready}, 64'd1);
    step();
    idle();
    check("rsp_valid_n1", {63'd0, bus.rsp_valid}, 64'd0);
    step();
    check("rsp_valid_n2", {63'd0, bus.rsp_valid}, 64'd1);
    check("rsp_data_n2", bus.rsp_data, exp_data);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ref_mem[i] = 64'd0;
      sram[i]    = 64'd0;
    end
    idle();
    bus.rsp_ready = 1'b1;
    bus.Q1 = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_ce0", {63'd0, bus.CE0}, 64'd0);
    check("rst_ce1", {63'd0, bus.CE1}, 64'd0);
    check("rst_count", {62'd0, dbg_count}, 64'd0);
    check("rst_prio", {63'd0, dbg_prio_wr}, 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    check("post_rst_rd_ready", {63'd0, bus.rd_ready}, 64'd1);

    // Basic write then read
    do_write(14'h0005, 64'hDEADBEEF_CAFEF00D, {64{1'b1}});
    step();
    read_latency(14'h0005, 64'hDEADBEEF_CAFEF00D);
    drain();

    // Bit mask
    do_write(14'h2001, {64{1'b1}}, {64{1'b1}});
    do_write(14'h2001, 64'd0, 64'h00000000_FFFFFFFF);
    read_latency(14'h2001, 64'hFFFFFFFF_00000000);
    drain();

    // Back-to-back reads with rsp_ready high
    begin
      int base;
      base = n_rd_hs;
      bus.rd_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        bus.rd_addr = {$urandom_range(0, 1) == 1, 9'd0, 4'($urandom_range(0, 15))};
        step();
      end
      idle();
      #1;
      check("b2b_reads", 64'(n_rd_hs - base), 64'd8);
      drain();
    end

    // Same-bank conflict: read, write, read, write
    check("prio_before_conflict", {63'd0, dbg_prio_wr}, 64'd0);
    bus.wr_valid = 1'b1; bus.wr_addr = 14'h0010; bus.wr_data = 64'h1111_2222_3333_4444;
    bus.wr_mask = {64{1'b1}};
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h0020;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("conf_rd_ready", {63'd0, bus.rd_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
      check("conf_wr_ready", {63'd0, bus.wr_ready}, (i % 2 == 1) ? 64'd1 : 64'd0);
      check("conf_ce1", {63'd0, bus.CE1}, (i % 2 == 0) ? 64'd1 : 64'd0);
      step();
      check("conf_prio", {63'd0, dbg_prio_wr}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    drain();

    // Different banks: both complete, priority untouched
    bus.wr_valid = 1'b1; bus.wr_addr = 14'h0010; bus.wr_data = 64'h5555_6666_7777_8888;
    bus.wr_mask = {64{1'b1}};
    bus.rd_valid = 1'b1; bus.rd_addr = 14'h2010;
    #1;
    check("split_wr_ready", {63'd0, bus.wr_ready}, 64'd1);
    check("split_rd_ready", {63'd0, bus.rd_ready}, 64'd1);
    check("split_ce0", {63'd0, bus.CE0}, 64'd1);
    check("split_ce1", {63'd0, bus.CE1}, 64'd1);
    step();
    idle();
    check("split_prio", {63'd0, dbg_prio_wr}, 64'd0);
    drain();

    // Backpressure: only two reads fit while rsp_ready is low
    begin
      int base;
      base = n_rd_hs;
      bus.rsp_ready = 1'b0;
      bus.rd_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
        bus.rd_addr = {$urandom_range(0, 1) == 1, 9'd0, 4'($urandom_range(0, 15))};
        step();
      end
      #1;
      check("bp_accepted", 64'(n_rd_hs - base), 64'd2);
      check("bp_rd_ready", {63'd0, bus.rd_ready}, 64'd0);
      check("bp_count", {62'd0, dbg_count}, 64'd2);
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_resume", {63'd0, bus.rd_ready}, 64'd1);
      repeat (4) step();
      drain();
    end

    // Reset while a read is in flight
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 14'h0005;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", {62'd0, dbg_count}, 64'd0);
    check("mid_rst_inflight", {63'd0, dbg_inflight}, 64'd0);
    check("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    end
    read_latency(14'h0005, 64'hDEADBEEF_CAFEF00D);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.wr_valid  = $urandom_range(0, 1) == 1;
      bus.wr_addr   = {$urandom_range(0, 1) == 1, 9'd0, 4'($urandom_range(0, 15))};
      bus.wr_data   = {$urandom, $urandom};
      bus.wr_mask   = ($urandom_range(0, 1) == 1) ? {64{1'b1}} : {$urandom, $urandom};
      bus.rd_valid  = $urandom_range(0, 1) == 1;
      bus.rd_addr   = {$urandom_range(0, 1) == 1, 9'd0, 4'($urandom_range(0, 15))};
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    idle();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("final_drain", 64'(exp_q.size()), 64'd0);
    check("random_rsp_seen", {63'd0, n_rsp > 20}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram64_be_port_adapter.md
SRAM64_BE_PORT_ADAPTER -- requirements
Module: sram64_be_port_adapter

Interface
REQ-001: Parameters: none; the block is fixed to a 14-bit word address, 64-bit data, 2 banks selected by address bit 13, and a 2-entry response FIFO.
REQ-002: CLK  in  1  single clock; all state updates on its rising edge.
REQ-003: RSTN  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion is used synchronously to CLK.
REQ-004: wr_valid / wr_ready  in / out  1 / 1  write request handshake.
REQ-005: wr_addr / wr_data / wr_mask  in  14 / 64 / 64  write word address, data, per-bit write enable.
REQ-006: rd_valid / rd_ready  in / out  1 / 1  read request handshake.
REQ-007: rd_addr  in  14  read word address.
REQ-008: rsp_valid / rsp_ready  out / in  1 / 1  read response handshake.
REQ-009: rsp_data  out  64  read response data.
REQ-010: CE0, A0[13:0], D0[63:0], WE0, WEM0[63:0]  out  write port to the downstream dual-bank SRAM.
REQ-011: CE1, A1[13:0]  out  read port to the downstream SRAM; Q1[63:0]  in  read data, valid exactly one cycle after CE1.

Function
REQ-012: A handshake completes when valid and ready are both high in the same cycle; ready does not wait for a prior valid, and payload is sampled in the handshake cycle only.
REQ-013: Write issue is combinational: CE0 = WE0 = wr_valid & wr_ready; A0/D0/WEM0 = wr_addr/wr_data/wr_mask when CE0, else all zero.
REQ-014: Read issue is combinational: CE1 = rd_valid & rd_ready; A1 = rd_addr when CE1, else zero.
REQ-015: credit = (count + inflight - pop) < 2, where count = FIFO occupancy (0..2), inflight = 1-bit register set on a read handshake, pop = rsp_valid & rsp_ready.
REQ-016: conflict = wr_valid & rd_valid & credit & (wr_addr[13] == rd_addr[13]).
REQ-017: wr_ready = ~conflict | prio_wr; rd_ready = credit & (~conflict | ~prio_wr); CE0 and CE1 are never both high to the same bank.
REQ-018: prio_wr (1-bit register) toggles at the end of every conflict cycle and holds otherwise; first conflict after reset grants the read.
REQ-019: Requests to different banks in the same cycle both complete with no priority change.
REQ-020: inflight <= CE1 every cycle; when inflight is 1, Q1 is pushed into the FIFO at the end of that cycle.
REQ-021: Read latency: handshake in cycle N -> rsp_valid = 1 with that data in cycle N+2 at the earliest; responses return in request order.
REQ-022: rsp_valid = (count != 0); rsp_data = FIFO head; push and pop in the same cycle leave count unchanged.
REQ-023: With rsp_ready held high, back-to-back reads sustain one handshake per cycle.
REQ-024: The FIFO never overflows: credit accounting guarantees count + inflight <= 2 at all times; overflow is an assertion failure in simulation.
REQ-025: No address hazard checking is performed; same-address write then read in later cycles returns the written data by SRAM ordering.

Reset
REQ-026: On RSTN low: count = 0, inflight = 0, prio_wr = 0, FIFO pointers = 0; rsp_valid = 0, CE0 = CE1 = 0 whenever request valids are low.
REQ-027: Reset during an outstanding read discards it; no response is produced for it after reset release.
REQ-028: After reset release, wr_ready = 1 and rd_ready = 1 when no conflict exists.

Verification
REQ-029: Write 0x0005 data 0xDEADBEEF_CAFEF00D mask all-ones; read 0x0005 in a later cycle -> rsp_data = 0xDEADBEEF_CAFEF00D, rsp_valid two cycles after the read handshake.
REQ-030: Mask test: write all-ones to 0x2001, then write 0 with mask 0x00000000_FFFFFFFF; read -> 0xFFFFFFFF_00000000.
REQ-031: Same-bank conflict held for 4 cycles (wr 0x0010, rd 0x0020, both valid) -> grants read, write, read, write; prio_wr alternates.
REQ-032: Different-bank simultaneous wr 0x0010 and rd 0x2010 -> both ready in the same cycle, CE0 = CE1 = 1, prio_wr unchanged.
REQ-033: rsp_ready held low, reads streamed -> exactly 2 read handshakes accepted, rd_ready low thereafter; raising rsp_ready drains both responses in order and reads resume.
REQ-034: RSTN pulsed low one cycle after a read handshake -> rsp_valid stays 0 after release, count = 0, and the next read returns correctly.
